// File: rtl/dual_priority_grant_decoder.sv
// dual_priority_grant_decoder
//
// Return path of the 15-bit dual-priority encoder. Takes a {first, second} index pair
// (1..15, 0 = none) through a valid/ready handshake and turns each index back into a
// one-hot grant. It serves the two winners in order. Each grant is held for at most
// HOLD_CYCLES cycles, or less if the grantee releases early. One idle gap cycle separates
// the two grants.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     index pair valid
//   in_ready     block can accept a pair (high only in idle)
//   first        highest-priority index, 0 = none
//   second       second-priority index, 0 = none
//   release_req  current grantee releases early (ignored outside grant states)
//   grant        one-hot grant, bit i = requester i, zero when idle
//   busy         a grant sequence is in progress
//   done         one-cycle pulse as the sequence completes
//   err          one-cycle pulse after an illegal pair is accepted
module dual_priority_grant_decoder #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  first,
  input  logic [3:0]  second,
  input  logic        release_req,
  output logic [15:1] grant,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StGrant1,
    StGap,
    StGrant2,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      first_q, first_d;
  logic [3:0]      second_q, second_d;
  logic [15:1]     grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic accept;
  logic illegal;
  logic hold_end;

  // Index 0 decodes to all zeros, so an empty slot can never assert a grant line.
  function automatic logic [15:1] decode(input logic [3:0] idx);
    logic [15:1] oh;
    oh = '0;
    for (int i = 1; i <= 15; i++) begin
      oh[i] = (idx == 4'(i));
    end
    return oh;
  endfunction

  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid && in_ready;
  // A second winner has to rank strictly below a real first winner.
  assign illegal  = (second != 4'd0) && ((first == 4'd0) || (second >= first));
  // When release_req and the hold limit happen in the same cycle, the grant exits once.
  assign hold_end = (cnt_q == HoldMax) || release_req;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    second_d = second_q;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          first_d  = first;
          second_d = illegal ? 4'd0 : second;
          err_d    = illegal;
          cnt_d    = CntOne;
          state_d  = (first != 4'd0) ? StGrant1 : StDone;
        end
      end
      StGrant1: begin
        if (hold_end) begin
          state_d = (second_q != 4'd0) ? StGap : StDone;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StGap: begin
        cnt_d   = CntOne;
        state_d = StGrant2;
      end
      StGrant2: begin
        if (hold_end) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // These outputs are decoded from the next state, so the registered outputs line up
  // with the state they describe.
  always_comb begin
    grant_d = '0;
    case (state_d)
      StGrant1: grant_d = decode(first_d);
      StGrant2: grant_d = decode(second_d);
      default:  grant_d = '0;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      first_q  <= 4'd0;
      second_q <= 4'd0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      second_q <= second_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

  grant_onehot0_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  ready_idle_a: assert property (@(posedge clk) disable iff (!rst_n) in_ready |-> !busy_q);

endmodule

// File: tb/tb_dual_priority_grant_decoder.sv
module tb_dual_priority_grant_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  first;
  logic [3:0]  second;
  logic        release_req;
  logic [15:1] grant;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks;
  int n_errors;

  logic [18:0] obs;
  assign obs = {grant, busy, done, err, in_ready};

  dual_priority_grant_decoder #(
    .HOLD_CYCLES(4)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .first      (first),
    .second     (second),
    .release_req(release_req),
    .grant      (grant),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {grant, busy, done, err, in_ready} for a granted index (0 = no grant).
  function automatic logic [18:0] expv(input int idx, input bit b, input bit d, input bit e,
                                       input bit r);
    logic [15:1] g;
    g = '0;
    if (idx != 0) g = 15'(1) << (idx - 1);
    return {g, b, d, e, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair in idle and leave the bench at the first cycle after acceptance.
  task automatic accept_pair(input logic [3:0] f, input logic [3:0] s);
    in_valid = 1'b1;
    first    = f;
    second   = s;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (obs !== expv(0, 0, 0, 0, 1)) begin
      n_errors++;
      $display("FAIL reset_hold: got %h want %h", obs, expv(0, 0, 0, 0, 1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (obs !== expv(0, 0, 0, 0, 1)) begin
      n_errors++;
      $display("FAIL reset_release: got %h want %h", obs, expv(0, 0, 0, 0, 1));
    end
  endtask

  task automatic test_full_pair();
    int idx;
    accept_pair(4'd13, 4'd6);
    for (int c = 0; c <= 10; c++) begin
      idx = (c < 4) ? 13 : (c == 4) ? 0 : (c < 9) ? 6 : 0;
      n_checks++;
      if (obs !== expv(idx, c < 10, c == 9, 0, c == 10)) begin
        n_errors++;
        $display("FAIL full_pair cyc %0d: got %h want %h", c, obs,
                 expv(idx, c < 10, c == 9, 0, c == 10));
      end
      step();
    end
  endtask

  task automatic test_single();
    accept_pair(4'd9, 4'd0);
    for (int c = 0; c <= 5; c++) begin
      n_checks++;
      if (obs !== expv((c < 4) ? 9 : 0, c < 5, c == 4, 0, c == 5)) begin
        n_errors++;
        $display("FAIL single cyc %0d: got %h want %h", c, obs,
                 expv((c < 4) ? 9 : 0, c < 5, c == 4, 0, c == 5));
      end
      step();
    end
  endtask

  task automatic test_early_release();
    int idx;
    accept_pair(4'd5, 4'd2);
    for (int c = 0; c <= 5; c++) begin
      release_req = (c == 1) || (c == 3);
      idx = (c < 2) ? 5 : (c == 3) ? 2 : 0;
      n_checks++;
      if (obs !== expv(idx, c < 5, c == 4, 0, c == 5)) begin
        n_errors++;
        $display("FAIL early_release cyc %0d: got %h want %h", c, obs,
                 expv(idx, c < 5, c == 4, 0, c == 5));
      end
      step();
    end
    release_req = 1'b0;
  endtask

  task automatic test_release_at_limit();
    int idx;
    accept_pair(4'd3, 4'd1);
    for (int c = 0; c <= 8; c++) begin
      if (c == 3) release_req = 1'b1;
      idx = (c < 4) ? 3 : (c == 5) ? 1 : 0;
      n_checks++;
      if (obs !== expv(idx, c < 7, c == 6, 0, c >= 7)) begin
        n_errors++;
        $display("FAIL release_limit cyc %0d: got %h want %h", c, obs,
                 expv(idx, c < 7, c == 6, 0, c >= 7));
      end
      step();
    end
    release_req = 1'b0;
  endtask

  task automatic test_illegal();
    accept_pair(4'd4, 4'd7);
    for (int c = 0; c <= 5; c++) begin
      n_checks++;
      if (obs !== expv((c < 4) ? 4 : 0, c < 5, c == 4, c == 0, c == 5)) begin
        n_errors++;
        $display("FAIL illegal_order cyc %0d: got %h want %h", c, obs,
                 expv((c < 4) ? 4 : 0, c < 5, c == 4, c == 0, c == 5));
      end
      step();
    end
    accept_pair(4'd0, 4'd3);
    for (int c = 0; c <= 1; c++) begin
      n_checks++;
      if (obs !== expv(0, c == 0, c == 0, c == 0, c == 1)) begin
        n_errors++;
        $display("FAIL illegal_empty cyc %0d: got %h want %h", c, obs,
                 expv(0, c == 0, c == 0, c == 0, c == 1));
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    accept_pair(4'd9, 4'd8);
    for (int c = 0; c <= 16; c++) begin
      if (c == 5) begin
        in_valid = 1'b1;
        first    = 4'd7;
        second   = 4'd0;
      end
      if (c == 11) in_valid = 1'b0;
      idx = (c < 4) ? 9 : (c >= 5 && c < 9) ? 8 : (c >= 11 && c < 15) ? 7 : 0;
      n_checks++;
      if (obs !== expv(idx, (c != 10) && (c != 16), (c == 9) || (c == 15), 0,
                       (c == 10) || (c == 16))) begin
        n_errors++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", c, obs,
                 expv(idx, (c != 10) && (c != 16), (c == 9) || (c == 15), 0,
                      (c == 10) || (c == 16)));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    accept_pair(4'd15, 4'd0);
    n_checks++;
    if (obs !== expv(15, 1, 0, 0, 0)) begin
      n_errors++;
      $display("FAIL mid_pre cyc 0: got %h want %h", obs, expv(15, 1, 0, 0, 0));
    end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== expv(0, 0, 0, 0, 1)) begin
      n_errors++;
      $display("FAIL mid_async: got %h want %h", obs, expv(0, 0, 0, 0, 1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      n_checks++;
      if (obs !== expv(0, 0, 0, 0, 1)) begin
        n_errors++;
        $display("FAIL mid_no_done cyc %0d: got %h want %h", c, obs, expv(0, 0, 0, 0, 1));
      end
    end
    accept_pair(4'd1, 4'd0);
    n_checks++;
    if (obs !== expv(1, 1, 0, 0, 0)) begin
      n_errors++;
      $display("FAIL mid_restart: got %h want %h", obs, expv(1, 1, 0, 0, 0));
    end
    for (int c = 0; c < 5; c++) step();
    n_checks++;
    if (obs !== expv(0, 0, 0, 0, 1)) begin
      n_errors++;
      $display("FAIL mid_restart_idle: got %h want %h", obs, expv(0, 0, 0, 0, 1));
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    first       = 4'd0;
    second      = 4'd0;
    release_req = 1'b0;
    test_reset();
    test_full_pair();
    test_single();
    test_early_release();
    test_release_at_limit();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dual_priority_grant_decoder.md
Name: dual_priority_grant_decoder

Overview:
- Return-path counterpart of the 15-bit dual-priority encoder.
- Accepts a {first, second} index pair (1..15, 0 = none) through a valid/ready handshake and decodes each index back into a one-hot grant on a 15-bit vector.
- Serves the two winners in order, each for a bounded hold window, with a one-cycle non-overlap gap between them.
- Sits between the encoder output and the requesters' grant lines.

Parameters:
HOLD_CYCLES, 4, maximum cycles each grant is held (legal range 1..255)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  index pair valid
- in_ready  output  1  block can accept a pair
- first  input  4  highest-priority index (0 = none)
- second  input  4  second-priority index (0 = none)
- release_req  input  1  current grantee releases early
- grant  output  15  one-hot grant, bit i (1..15) = requester i; all zeros when idle
- busy  output  1  a grant sequence is in progress
- done  output  1  one-cycle pulse when the sequence completes
- err  output  1  one-cycle pulse when an illegal pair is accepted

Behaviour:
- Reset is asynchronous on rst_n low. While in reset:
  - state = IDLE
  - grant = 0, busy = 0, done = 0, err = 0
  - hold counter = 0, captured indices = 0
- in_ready = (state == IDLE). It is combinational from state and is therefore 1 immediately after reset release.
- Acceptance: a pair is accepted on a rising edge where in_valid && in_ready. first and second are registered on that edge.
- Legality check (at acceptance):
  - A pair is illegal when second != 0 and (first == 0 or second >= first).
  - An illegal pair raises err = 1 for the one cycle following acceptance.
  - The captured second is forced to 0; first is kept as given.
- Hold counter width is $clog2(HOLD_CYCLES+1); it is loaded with 1 on entry to each GRANT state.
- States and transitions:
  - IDLE: grant = 0, busy = 0.
    - On acceptance with first != 0, go to GRANT1.
    - On acceptance with first == 0, go to DONE.
  - GRANT1: grant = one-hot(first), busy = 1.
    - Leave when counter == HOLD_CYCLES or release_req == 1, whichever occurs first; the exit is registered at the end of that cycle.
    - Exit to GAP if captured second != 0, otherwise to DONE.
  - GAP: grant = 0, busy = 1, exactly one cycle, then go to GRANT2. GAP guarantees the two grants never overlap or appear back to back.
  - GRANT2: grant = one-hot(second), busy = 1. Same exit rule as GRANT1; exit goes to DONE.
  - DONE: grant = 0, busy = 1, done = 1 for exactly one cycle, then go to IDLE.
- grant, done and err are registered outputs; grant is never multi-hot.
- Latency and sequence length:
  - Grant first appears in the cycle after acceptance.
  - Minimum sequence with release_req held high and both indices valid: GRANT1 1 cycle, GAP 1, GRANT2 1, DONE 1.
- Boundary conditions:
  - release_req asserted in IDLE, GAP or DONE is ignored.
  - release_req coinciding with counter == HOLD_CYCLES produces a single exit; no double advance.
  - HOLD_CYCLES = 1: each grant lasts exactly one cycle regardless of release_req.
  - in_valid while busy: not accepted; the pair must be held by the source.
  - Acceptance happens only in IDLE, so done and a new acceptance never coincide. The next acceptance is possible the cycle after DONE.
  - Index 15 and index 1 decode to grant[14] and grant[0] bit positions respectively, i.e. grant bit i-1 of [14:0] or bit i of [15:1]. The port is declared [15:1].
- Reset mid-operation: grant drops to 0 asynchronously, the sequence is abandoned, and no done pulse is issued.

Test Plan:
1. first=13, second=6, HOLD_CYCLES=4, release_req=0 -> grant[13] for 4 cycles, 1 zero cycle, grant[6] for 4 cycles, done pulse, in_ready=1 next cycle.
2. first=9, second=0 -> grant[9] for 4 cycles, then done one cycle later; no GAP cycle, grant[*]=0 throughout except bit 9.
3. first=5, second=2, release_req pulsed in 2nd GRANT1 cycle and 1st GRANT2 cycle -> grant[5] 2 cycles, gap 1, grant[2] 1 cycle, done.
4. Illegal pair first=4, second=7 -> err=1 cycle after acceptance, grant[4] for 4 cycles, no GRANT2, done. Also first=0, second=3 -> err pulse, no grant, done the cycle after acceptance.
5. in_valid held high with new pair during GRANT2 -> in_ready=0, pair accepted on the cycle after done; first grant 2 cycles after done.
6. rst_n low during GRANT1 of first=15 -> grant=0, busy=0 asynchronously, no done. After release, in_ready=1 and a new pair first=1 gives grant[1].
